// File: rtl/echo_delay_ctrl.sv
// Delay-line sequencer for the echo effect: computes the tap address, mixes
// the delayed sample into the output and writes input plus feedback back.
module echo_delay_ctrl #(
  parameter int DATA_WIDTH = 31,
  parameter int ADDR_WIDTH = 15,
  parameter int SIZE       = 20000,
  parameter int GAIN_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  IN_VALID,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  output logic                  IN_READY,
  input  logic [ADDR_WIDTH-1:0] DELAY,
  input  logic [GAIN_WIDTH-1:0] GAIN,
  input  logic [GAIN_WIDTH-1:0] FB_GAIN,
  output logic                  OUT_VALID,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_WADDR,
  output logic [ADDR_WIDTH-1:0] MEM_RADDR,
  output logic [DATA_WIDTH-1:0] MEM_DI,
  input  logic [DATA_WIDTH-1:0] MEM_DO
);

  localparam int SW = DATA_WIDTH + 2;
  localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]   SIZE_F = (ADDR_WIDTH+1)'(SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, RD, MIX, WR} state_t;

  state_t state, state_n;

  logic signed [DATA_WIDTH-1:0] x_r;
  logic        [GAIN_WIDTH-1:0] gain_r, fb_r;
  logic        [ADDR_WIDTH-1:0] d_r, d_n, raddr_n, wptr;
  logic        [ADDR_WIDTH:0]   fill;
  logic signed [DATA_WIDTH-1:0] tap, wet, fbw;
  logic signed [SW-1:0]         wet_sum, fbw_sum;
  logic                         accept;

  // Q0.GAIN_WIDTH scaling: full-width signed product, then floor shift.
  function automatic logic signed [SW-1:0] scale(input logic signed [DATA_WIDTH-1:0] t,
                                                 input logic [GAIN_WIDTH-1:0] g);
    logic signed [PW-1:0] p;
    p = $signed({{(PW-DATA_WIDTH){t[DATA_WIDTH-1]}}, t}) *
        $signed({{(PW-GAIN_WIDTH){1'b0}}, g});
    return SW'(p >>> GAIN_WIDTH);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
    if ((v[SW-1:DATA_WIDTH-1] == '0) || (v[SW-1:DATA_WIDTH-1] == '1))
      return v[DATA_WIDTH-1:0];
    else if (v[SW-1])
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  assign accept = (state == IDLE) && IN_VALID && IN_READY;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = RD;
      RD:   state_n = MIX;
      MIX:  state_n = WR;
      WR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    d_n = DELAY;
    if (DELAY == '0)
      d_n = ADDR_WIDTH'(1);
    else if ({1'b0, DELAY} >= SIZE_F)
      d_n = LAST;
    raddr_n = (wptr >= d_n) ? wptr - d_n
                            : ADDR_WIDTH'({1'b0, wptr} + SIZE_F - {1'b0, d_n});
  end

  // Locations not yet written since reset read as silence.
  always_comb begin
    tap     = (fill >= {1'b0, d_r}) ? $signed(MEM_DO) : '0;
    wet_sum = $signed({{2{x_r[DATA_WIDTH-1]}}, x_r}) + scale(tap, gain_r);
    fbw_sum = $signed({{2{x_r[DATA_WIDTH-1]}}, x_r}) + scale(tap, fb_r);
    wet     = sat(wet_sum);
    fbw     = sat(fbw_sum);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      IN_READY  <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      MEM_WE    <= 1'b0;
      MEM_WADDR <= '0;
      MEM_RADDR <= '0;
      MEM_DI    <= '0;
      x_r       <= '0;
      gain_r    <= '0;
      fb_r      <= '0;
      d_r       <= '0;
      wptr      <= '0;
      fill      <= '0;
    end else begin
      IN_READY  <= (state_n == IDLE);
      OUT_VALID <= (state_n == WR);
      MEM_WE    <= (state_n == WR);
      if (accept) begin
        x_r       <= $signed(IN_DATA);
        gain_r    <= GAIN;
        fb_r      <= FB_GAIN;
        d_r       <= d_n;
        MEM_RADDR <= raddr_n;
      end
      if (state == MIX) begin
        OUT_DATA  <= wet;
        MEM_DI    <= fbw;
        MEM_WADDR <= wptr;
      end
      if (state == WR) begin
        wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
        fill <= (fill == SIZE_F) ? fill : fill + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Directed bench for echo_delay_ctrl with a registered-read dual-port memory
// model; delay line shortened to 16 words so wrap-around is reachable.
module tb_echo_delay_ctrl;

  localparam int DW = 31;
  localparam int AW = 15;
  localparam int GW = 8;
  localparam int SIZE = 16;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          IN_VALID = 1'b0;
  logic [DW-1:0] IN_DATA = '0;
  logic          IN_READY;
  logic [AW-1:0] DELAY = '0;
  logic [GW-1:0] GAIN = '0;
  logic [GW-1:0] FB_GAIN = '0;
  logic          OUT_VALID;
  logic [DW-1:0] OUT_DATA;
  logic          MEM_WE;
  logic [AW-1:0] MEM_WADDR;
  logic [AW-1:0] MEM_RADDR;
  logic [DW-1:0] MEM_DI;
  logic [DW-1:0] MEM_DO;

  int vectors = 0;
  int miscompares = 0;

  echo_delay_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE(SIZE), .GAIN_WIDTH(GW)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .DELAY(DELAY), .GAIN(GAIN), .FB_GAIN(FB_GAIN), .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA),
    .MEM_WE(MEM_WE), .MEM_WADDR(MEM_WADDR), .MEM_RADDR(MEM_RADDR), .MEM_DI(MEM_DI), .MEM_DO(MEM_DO)
  );

  always #5 CLK = ~CLK;

  // Memory model; preloaded with non-zero junk so unwritten reads are not silent.
  logic [DW-1:0] mem [0:SIZE-1];
  initial for (int i = 0; i < SIZE; i++) mem[i] = 31'h0123_4567 + DW'(i);
  always @(posedge CLK) begin
    if (MEM_WE) mem[MEM_WADDR[3:0]] <= MEM_DI;
    MEM_DO <= mem[MEM_RADDR[3:0]];
  end

  task automatic do_reset();
    @(posedge CLK); #1;
    RST_N = 1'b0; IN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  // Drives one sample, then scrambles the inputs; returns what the WR cycle shows.
  task automatic send(input logic signed [DW-1:0] x, input logic [AW-1:0] dly,
                      input logic [GW-1:0] g, input logic [GW-1:0] fb,
                      output logic signed [DW-1:0] out, output logic [AW-1:0] waddr,
                      output logic [AW-1:0] raddr, output logic [DW-1:0] di,
                      output logic we, output int lat);
    int w = 0;
    while (!IN_READY && w < 10) begin @(posedge CLK); #1; w++; end
    out = '0; waddr = '0; raddr = '0; di = '0; we = 1'b0; lat = -1;
    if (!IN_READY) begin
      vectors++; miscompares++;
      $display("FAIL ready_timeout: IN_READY=%0b required 1", IN_READY);
      return;
    end
    IN_VALID = 1'b1; IN_DATA = x; DELAY = dly; GAIN = g; FB_GAIN = fb;
    @(posedge CLK); #1;
    IN_VALID = 1'b0; IN_DATA = ~x; DELAY = dly + 15'd5; GAIN = ~g; FB_GAIN = ~fb;
    raddr = MEM_RADDR;
    lat = 1;
    while (!OUT_VALID && lat < 10) begin @(posedge CLK); #1; lat++; end
    out = OUT_DATA; waddr = MEM_WADDR; di = MEM_DI; we = MEM_WE;
  endtask

  task automatic test_reset();
    logic [3*AW+2*DW+2:0] all_out;
    @(posedge CLK); #1;
    RST_N = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      all_out = {IN_READY, OUT_VALID, MEM_WE, OUT_DATA, MEM_WADDR, MEM_RADDR, MEM_DI};
      vectors++;
      if (all_out !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got %h required 0", c, all_out);
      end
    end
    RST_N = 1'b1;
    @(posedge CLK); #1;
    vectors++;
    if (IN_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_release: got %0b required 1", IN_READY);
    end
    for (int c = 0; c < 6; c++) begin
      GAIN = GW'(c * 40); DELAY = AW'(c);
      @(posedge CLK); #1;
      vectors++;
      if ({MEM_WE, OUT_VALID, IN_READY} !== 3'b001) begin
        miscompares++;
        $display("FAIL idle_quiet cycle %0d: we/ov/rdy=%b required 001", c, {MEM_WE, OUT_VALID, IN_READY});
      end
    end
  endtask

  task automatic test_impulse();
    logic signed [DW-1:0] xin [5] = '{1000, 0, 0, 0, 0};
    logic signed [DW-1:0] exp [5] = '{1000, 0, 0, 500, 0};
    logic signed [DW-1:0] out; logic [AW-1:0] wa, ra; logic [DW-1:0] di; logic we; int lat;
    do_reset();
    for (int n = 0; n < 5; n++) begin
      send(xin[n], 15'd3, 8'd128, 8'd0, out, wa, ra, di, we, lat);
      vectors += 3;
      if (out !== exp[n]) begin
        miscompares++; $display("FAIL impulse_out[%0d]: got %0d required %0d", n, out, exp[n]);
      end
      if (lat !== 3 || we !== 1'b1) begin
        miscompares++; $display("FAIL impulse_latency[%0d]: lat=%0d we=%0b required 3/1", n, lat, we);
      end
      if (wa !== AW'(n)) begin
        miscompares++; $display("FAIL impulse_waddr[%0d]: got %0d required %0d", n, wa, n);
      end
    end
  endtask

  task automatic test_feedback();
    logic signed [DW-1:0] xin [5] = '{1024, 0, 0, 0, 0};
    logic signed [DW-1:0] exp [5] = '{1024, 0, 1020, 0, 510};
    logic signed [DW-1:0] out; logic [AW-1:0] wa, ra; logic [DW-1:0] di; logic we; int lat;
    do_reset();
    for (int n = 0; n < 5; n++) begin
      send(xin[n], 15'd2, 8'd255, 8'd128, out, wa, ra, di, we, lat);
      vectors++;
      if (out !== exp[n]) begin
        miscompares++; $display("FAIL feedback_out[%0d]: got %0d required %0d", n, out, exp[n]);
      end
      if (n == 2) begin
        vectors++;
        if (di !== 31'd512) begin
          miscompares++; $display("FAIL feedback_mem_di[2]: got %0d required 512", di);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [DW-1:0] pmax = 31'sd1073741823;
    logic signed [DW-1:0] nmin = -31'sd1073741824;
    logic signed [DW-1:0] out; logic [AW-1:0] wa, ra; logic [DW-1:0] di; logic we; int lat;
    do_reset();
    send(pmax, 15'd1, 8'd255, 8'd255, out, wa, ra, di, we, lat);
    send(pmax, 15'd1, 8'd255, 8'd255, out, wa, ra, di, we, lat);
    vectors++;
    if (out !== pmax) begin
      miscompares++; $display("FAIL sat_pos: got %0d required %0d", out, pmax);
    end
    do_reset();
    send(nmin, 15'd1, 8'd255, 8'd255, out, wa, ra, di, we, lat);
    send(nmin, 15'd1, 8'd255, 8'd255, out, wa, ra, di, we, lat);
    vectors += 2;
    if (out !== nmin) begin
      miscompares++; $display("FAIL sat_neg: got %0d required %0d", out, nmin);
    end
    if (di !== nmin) begin
      miscompares++; $display("FAIL sat_neg_mem_di: got %0d required %0d", $signed(di), nmin);
    end
  endtask

  task automatic test_wrap();
    logic signed [DW-1:0] xs [40];
    logic signed [DW-1:0] exp;
    logic signed [DW-1:0] out; logic [AW-1:0] wa, ra; logic [DW-1:0] di; logic we; int lat;
    do_reset();
    for (int n = 0; n < 40; n++) xs[n] = DW'(n * 37 - 300);
    for (int n = 0; n < 40; n++) begin
      send(xs[n], 15'd15, 8'd128, 8'd0, out, wa, ra, di, we, lat);
      exp = (n >= 15) ? xs[n] + (xs[n-15] >>> 1) : xs[n];
      vectors += 2;
      if (out !== exp) begin
        miscompares++; $display("FAIL wrap_out[%0d]: got %0d required %0d", n, out, exp);
      end
      if (wa !== AW'(n % 16)) begin
        miscompares++; $display("FAIL wrap_waddr[%0d]: got %0d required %0d", n, wa, n % 16);
      end
    end
  endtask

  task automatic test_clamp();
    logic signed [DW-1:0] out; logic [AW-1:0] wa, ra; logic [DW-1:0] di; logic we; int lat;
    do_reset();
    send(400, 15'd0, 8'd128, 8'd0, out, wa, ra, di, we, lat);
    vectors += 2;
    if (ra !== 15'd15) begin
      miscompares++; $display("FAIL delay0_raddr: got %0d required 15", ra);
    end
    if (out !== 31'sd400) begin
      miscompares++; $display("FAIL delay0_out0: got %0d required 400", out);
    end
    send(0, 15'd0, 8'd128, 8'd0, out, wa, ra, di, we, lat);
    vectors += 2;
    if (ra !== 15'd0) begin
      miscompares++; $display("FAIL delay0_raddr1: got %0d required 0", ra);
    end
    if (out !== 31'sd200) begin
      miscompares++; $display("FAIL delay0_out1: got %0d required 200", out);
    end
    do_reset();
    send(1000, 15'd20, 8'd128, 8'd0, out, wa, ra, di, we, lat);
    vectors++;
    if (ra !== 15'd1) begin
      miscompares++; $display("FAIL delay20_raddr: got %0d required 1", ra);
    end
    for (int n = 1; n < 16; n++) send(0, 15'd20, 8'd128, 8'd0, out, wa, ra, di, we, lat);
    vectors++;
    if (out !== 31'sd500) begin
      miscompares++; $display("FAIL delay20_out15: got %0d required 500", out);
    end
  endtask

  task automatic test_reset_mid_op();
    logic signed [DW-1:0] out; logic [AW-1:0] wa, ra; logic [DW-1:0] di; logic we; int lat;
    do_reset();
    send(100, 15'd1, 8'd255, 8'd255, out, wa, ra, di, we, lat);
    send(200, 15'd1, 8'd255, 8'd255, out, wa, ra, di, we, lat);
    send(300, 15'd1, 8'd255, 8'd255, out, wa, ra, di, we, lat);
    @(posedge CLK); #1;
    IN_VALID = 1'b1; IN_DATA = 31'd5555;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if (MEM_WE !== 1'b0 || OUT_VALID !== 1'b0) begin
        miscompares++; $display("FAIL midreset_dropped cycle %0d: we=%0b ov=%0b required 0/0", c, MEM_WE, OUT_VALID);
      end
      @(posedge CLK); #1;
    end
    send(777, 15'd1, 8'd255, 8'd255, out, wa, ra, di, we, lat);
    vectors += 3;
    if (wa !== 15'd0) begin
      miscompares++; $display("FAIL midreset_waddr: got %0d required 0", wa);
    end
    if (out !== 31'sd777) begin
      miscompares++; $display("FAIL midreset_out: got %0d required 777", out);
    end
    if (di !== 31'd777) begin
      miscompares++; $display("FAIL midreset_mem_di: got %0d required 777", di);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_feedback();
    test_saturation();
    test_wrap();
    test_clamp();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
